mem_stage: RTL

- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register and consumes its result (address), Data2 (store data), Imm32, retAddr, rd and decoded control fields.
- Drives a valid/ready data-memory bus and performs byte/halfword/word alignment and load extension.
- Stalls the pipeline while a memory access is outstanding.
- Registers the write-back payload for the WB stage.

---
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register.
// Drives a valid/ready data bus, aligns stores, extends loads.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [2:0]  memSizeIn,
  input  logic        regWriteIn,
  input  logic [1:0]  wbSelIn,
  input  logic [31:0] resultIn,
  input  logic [31:0] Data2In,
  input  logic [31:0] Imm32In,
  input  logic [31:0] retAddrIn,
  input  logic [4:0]  rdIn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        regWriteOut,
  output logic [4:0]  rdOut,
  output logic [31:0] wbDataOut
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        ld_wb_q, ld_wb_d;
  logic [31:0] alt_wb_q, alt_wb_d;
  logic        rw_c_q, rw_c_d;
  logic [4:0]  rd_c_q, rd_c_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        mem_op;
  logic        aligned;
  logic        stall_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] wb_mux;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  always_comb begin
    mem_op = memReadIn | memWriteIn;
    be_c = 4'b1111;
    wdata_c = Data2In;
    aligned = (resultIn[1:0] == 2'b00);
    unique case (memSizeIn[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_c = 4'b0001 << resultIn[1:0];
        wdata_c = {4{Data2In[7:0]}};
      end
      2'b01: begin
        aligned = ~resultIn[0];
        be_c = 4'b0011 << resultIn[1:0];
        wdata_c = {2{Data2In[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    wb_mux = resultIn;
    unique case (wbSelIn)
      2'b10: wb_mux = retAddrIn;
      2'b11: wb_mux = Imm32In;
      default: wb_mux = resultIn;
    endcase
  end

  always_comb begin
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_ext = dmem_rdata;
    unique case (size_q[1:0])
      2'b00: ld_ext = {{24{~size_q[2] & byte_sel[7]}}, byte_sel};
      2'b01: ld_ext = {{16{~size_q[2] & half_sel[15]}}, half_sel};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    ld_wb_d     = ld_wb_q;
    alt_wb_d    = alt_wb_q;
    rw_c_d      = rw_c_q;
    rd_c_d      = rd_c_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    reg_write_d = 1'b0;
    rd_d        = 5'd0;
    wb_data_d   = wb_data_q;
    stall_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          stall_c  = 1'b1;
          state_d  = ACCESS;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = memWriteIn;
          addr_d   = {resultIn[31:2], 2'b00};
          be_d     = be_c;
          wdata_d  = wdata_c;
          size_d   = memSizeIn;
          off_d    = resultIn[1:0];
          ld_wb_d  = memReadIn & (wbSelIn == 2'b01);
          alt_wb_d = wb_mux;
          rw_c_d   = regWriteIn;
          rd_c_d   = rdIn;
        end else if (mem_op) begin
          misalign_d = 1'b1;
        end else begin
          reg_write_d = regWriteIn & (rdIn != 5'd0);
          rd_d        = rdIn;
          wb_data_d   = wb_mux;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (dmem_ready) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          reg_write_d = rw_c_q & (rd_c_q != 5'd0);
          rd_d        = rd_c_q;
          wb_data_d   = ld_wb_q ? ld_ext : alt_wb_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      ld_wb_q     <= 1'b0;
      alt_wb_q    <= '0;
      rw_c_q      <= 1'b0;
      rd_c_q      <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      ld_wb_q     <= ld_wb_d;
      alt_wb_q    <= alt_wb_d;
      rw_c_q      <= rw_c_d;
      rd_c_q      <= rd_c_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign stall       = stall_c;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;
  assign regWriteOut = reg_write_q;
  assign rdOut       = rd_q;
  assign wbDataOut   = wb_data_q;

endmodule
